// File: rtl/audio_pwm_out.sv
// Multi-channel audio modulator: PWM or first-order sigma-delta (PDM) outputs
// fed from a single-entry sample buffer that reloads at each period boundary.
module audio_pwm_out #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [WIDTH-1:0]              i_top,
    input  logic                          i_mode,
    input  logic [CHANNELS*(WIDTH+1)-1:0] i_sample,
    input  logic                          i_sample_valid,
    output logic                          o_sample_ready,
    output logic [CHANNELS-1:0]           o_pwm,
    output logic [CHANNELS-1:0]           o_pwm_n,
    output logic                          o_cycle_end,
    output logic                          o_underrun
);

    localparam int SW = WIDTH + 1;
    localparam logic [SW-1:0] FULL_SCALE = {1'b1, {WIDTH{1'b0}}};

    // Samples above full scale would overflow the accumulator step.
    function automatic logic [SW-1:0] sat_sample(input logic [SW-1:0] s);
        return (s > FULL_SCALE) ? FULL_SCALE : s;
    endfunction

    logic [WIDTH-1:0]      counter;
    logic [WIDTH-1:0]      top_q;
    logic                  mode_q;
    logic                  pending_full;
    logic [CHANNELS*SW-1:0] pending_q;
    logic [CHANNELS*SW-1:0] active_q;
    logic [WIDTH-1:0]      acc_q [CHANNELS];

    logic                  period_end;
    logic                  accept;
    logic                  mode_change;
    logic [CHANNELS-1:0]   pwm_p0;
    logic [WIDTH+1:0]      sum_p0 [CHANNELS];
    logic [WIDTH-1:0]      acc_p0 [CHANNELS];

    assign period_end     = (counter == top_q);
    assign accept         = i_sample_valid && !pending_full;
    assign mode_change    = period_end && (i_mode != mode_q);
    assign o_sample_ready = !pending_full;
    assign o_cycle_end    = period_end;
    assign o_underrun     = period_end && !pending_full;

    // Stage p0: per-channel modulator decision from current counter/accumulator
    always_comb begin
        pwm_p0 = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            sum_p0[k] = {2'b00, acc_q[k]} + {1'b0, sat_sample(active_q[k*SW +: SW])};
            if (mode_q) begin
                pwm_p0[k] = |sum_p0[k][WIDTH+1:WIDTH];
                acc_p0[k] = sum_p0[k][WIDTH-1:0];
            end else begin
                pwm_p0[k] = ({1'b0, counter} < active_q[k*SW +: SW]);
                acc_p0[k] = '0;
            end
            if (mode_change) begin
                acc_p0[k] = '0;
            end
        end
    end

    // Stage p1: registered outputs, period bookkeeping and sample buffering
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            counter      <= '0;
            top_q        <= '1;
            mode_q       <= 1'b0;
            pending_full <= 1'b0;
            pending_q    <= '0;
            active_q     <= '0;
            o_pwm        <= '0;
            o_pwm_n      <= '1;
            for (int k = 0; k < CHANNELS; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            o_pwm   <= pwm_p0;
            o_pwm_n <= ~pwm_p0;
            for (int k = 0; k < CHANNELS; k++) begin
                acc_q[k] <= acc_p0[k];
            end

            if (period_end) begin
                counter <= '0;
                top_q   <= i_top;
                mode_q  <= i_mode;
            end else begin
                counter <= counter + WIDTH'(1);
            end

            // Accept and reload are exclusive: accept needs the buffer empty.
            if (period_end && pending_full) begin
                active_q     <= pending_q;
                pending_full <= 1'b0;
            end else if (accept) begin
                pending_q    <= i_sample;
                pending_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_audio_pwm_out.sv
// Directed bench for audio_pwm_out (WIDTH=8, CHANNELS=2): duty, underrun,
// buffering, top change, PDM density/clamp and mid-period reset.
module tb_audio_pwm_out;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 2;
    localparam int SW       = WIDTH + 1;

    logic                   i_clk = 1'b0;
    logic                   i_rst_n = 1'b0;
    logic [WIDTH-1:0]       i_top = 8'd255;
    logic                   i_mode = 1'b0;
    logic [CHANNELS*SW-1:0] i_sample = '0;
    logic                   i_sample_valid = 1'b0;
    logic                   o_sample_ready;
    logic [CHANNELS-1:0]    o_pwm;
    logic [CHANNELS-1:0]    o_pwm_n;
    logic                   o_cycle_end;
    logic                   o_underrun;

    audio_pwm_out #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_top          (i_top),
        .i_mode         (i_mode),
        .i_sample       (i_sample),
        .i_sample_valid (i_sample_valid),
        .o_sample_ready (o_sample_ready),
        .o_pwm          (o_pwm),
        .o_pwm_n        (o_pwm_n),
        .o_cycle_end    (o_cycle_end),
        .o_underrun     (o_underrun)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_err = 0;
    int stray_und = 0;
    int w_ones0, w_ones1, w_ncomp, w_nund, w_pos_end;
    logic [7:0] w_hist;

    function automatic logic [CHANNELS*SW-1:0] pack_samples(input int s0, input int s1);
        logic [SW-1:0] a0;
        logic [SW-1:0] a1;
        a0 = SW'(s0);
        a1 = SW'(s1);
        return {a1, a0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Returns the number of falling edges up to and including the period end.
    task automatic wait_end(output int n);
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
            if (o_underrun && !o_cycle_end) stray_und++;
        end while (!o_cycle_end && n < 2000);
        if (!o_cycle_end) chk("end_timeout", 32'd0, 32'd1);
    endtask

    // Sample len falling edges; sample j holds the output computed at counter j.
    task automatic count_window(input int len);
        w_ones0 = 0; w_ones1 = 0; w_ncomp = 0; w_nund = 0; w_pos_end = -1; w_hist = '0;
        for (int j = 0; j < len; j++) begin
            @(negedge i_clk);
            if (o_pwm[0]) w_ones0++;
            if (o_pwm[1]) w_ones1++;
            if (o_pwm_n !== ~o_pwm) w_ncomp++;
            if (o_underrun) w_nund++;
            if (o_cycle_end) w_pos_end = j;
            if (j < 8) w_hist[j] = o_pwm[0];
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rhi;

        // Reset values
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_pwm",       32'(o_pwm),          32'd0);
        chk("rst_pwm_n",     32'(o_pwm_n),        32'd3);
        chk("rst_ready",     32'(o_sample_ready), 32'd1);
        chk("rst_cycle_end", 32'(o_cycle_end),    32'd0);
        chk("rst_underrun",  32'(o_underrun),     32'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;

        // 64 / 256 duty before the first period end
        i_sample = pack_samples(64, 256);
        i_sample_valid = 1'b1;
        @(posedge i_clk); #1;
        i_sample_valid = 1'b0;
        @(negedge i_clk);
        chk("t1_ready_low", 32'(o_sample_ready), 32'd0);
        wait_end(n);
        chk("t1_first_len", n, 254);
        chk("t1_no_underrun", 32'(o_underrun), 32'd0);
        @(negedge i_clk);
        count_window(256);
        chk("t1_ch0_ones", w_ones0, 64);
        chk("t1_ch1_ones", w_ones1, 256);
        chk("t1_compl", w_ncomp, 0);
        chk("t1_underruns", w_nund, 1);
        chk("t1_end_pos", w_pos_end, 254);

        // Three starved periods
        for (int k = 0; k < 3; k++) begin
            wait_end(n);
            chk("t2_len", n, (k == 0) ? 255 : 256);
            chk("t2_underrun", 32'(o_underrun), 32'd1);
        end
        chk("t2_stray_underrun", stray_und, 0);
        @(negedge i_clk);
        count_window(256);
        chk("t2_hold_ch0", w_ones0, 64);
        chk("t2_hold_ch1", w_ones1, 256);

        // Back-to-back samples with valid held
        @(posedge i_clk); #1;
        i_sample = pack_samples(20, 10);
        i_sample_valid = 1'b1;
        @(negedge i_clk);
        chk("t3_ready_empty", 32'(o_sample_ready), 32'd1);
        @(posedge i_clk); #1;
        i_sample = pack_samples(40, 30);
        rhi = 0;
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
            if (o_sample_ready) rhi++;
        end while (!o_cycle_end && n < 2000);
        chk("t3_ready_held_low", rhi, 0);
        @(negedge i_clk);
        chk("t3_ready_after_end", 32'(o_sample_ready), 32'd1);
        @(posedge i_clk); #1;
        i_sample_valid = 1'b0;
        count_window(256);
        chk("t3_a_ch0", w_ones0, 20);
        chk("t3_a_ch1", w_ones1, 10);
        chk("t3_a_underruns", w_nund, 0);
        count_window(256);
        chk("t3_b_ch0", w_ones0, 40);
        chk("t3_b_ch1", w_ones1, 30);
        chk("t3_b_underruns", w_nund, 1);

        // Top change mid-period
        @(posedge i_clk); #1;
        i_top = 8'd99;
        i_sample = pack_samples(100, 50);
        i_sample_valid = 1'b1;
        @(posedge i_clk); #1;
        i_sample_valid = 1'b0;
        wait_end(n);
        chk("t4_old_period", n, 254);
        @(negedge i_clk);
        count_window(100);
        chk("t4_ch0_full", w_ones0, 100);
        chk("t4_ch1_half", w_ones1, 50);
        chk("t4_end_pos", w_pos_end, 98);
        chk("t4_compl", w_ncomp, 0);

        // PDM density and clamp
        @(posedge i_clk); #1;
        i_mode = 1'b1;
        i_sample = pack_samples(128, 300);
        i_sample_valid = 1'b1;
        @(posedge i_clk); #1;
        i_sample_valid = 1'b0;
        wait_end(n);
        chk("t5_len", n, 98);
        @(negedge i_clk);
        count_window(100);
        chk("t5_ch0_pattern", 32'(w_hist), 32'hAA);
        chk("t5_ch0_density", w_ones0, 50);
        chk("t5_ch1_clamp", w_ones1, 100);
        chk("t5_compl", w_ncomp, 0);

        // Reset mid-period with pending full
        @(posedge i_clk); #1;
        i_sample = pack_samples(2, 1);
        i_sample_valid = 1'b1;
        @(posedge i_clk); #1;
        i_sample_valid = 1'b0;
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("t6_pwm", 32'(o_pwm), 32'd0);
        chk("t6_pwm_n", 32'(o_pwm_n), 32'd3);
        chk("t6_ready", 32'(o_sample_ready), 32'd1);
        chk("t6_underrun", 32'(o_underrun), 32'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        i_mode = 1'b0;
        wait_end(n);
        chk("t6_len", n, 256);
        chk("t6_first_underrun", 32'(o_underrun), 32'd1);
        chk("t6_pwm_idle", 32'(o_pwm), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
